// File: rtl/icache_fill_unit.sv
// Direct-mapped read-only instruction cache with line refill through the memory controller.
// Optional macro ICACHE_FORWARD_EN: serve fetches from already-filled words of the line in flight.
module icache_fill_unit #(
    parameter int unsigned INDEX_BITS     = 4,
    parameter int unsigned LINE_WORD_BITS = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_inst,
    output logic        mc_valid,
    output logic        mc_wr,
    output logic [31:0] mc_addr,
    output logic [2:0]  mc_len,
    output logic [31:0] mc_data,
    input  logic        mc_ready,
    input  logic [31:0] mc_res
);

    localparam int unsigned TAG_BITS   = 32 - INDEX_BITS - LINE_WORD_BITS - 2;
    localparam int unsigned LINE_BITS  = 30 - LINE_WORD_BITS;
    localparam int unsigned NUM_LINES  = 1 << INDEX_BITS;
    localparam int unsigned NUM_WORDS  = NUM_LINES << LINE_WORD_BITS;
    localparam int unsigned DADDR_BITS = INDEX_BITS + LINE_WORD_BITS;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t                    r_state;
    logic [NUM_LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]       r_tag  [NUM_LINES];
    logic [31:0]               r_data [NUM_WORDS];
    logic [LINE_BITS-1:0]      r_fill_line;
    logic [LINE_WORD_BITS-1:0] r_fill_cnt;
    logic                      r_mc_valid;
    logic [31:0]               r_mc_addr;
    logic                      r_clear_pend;

    logic [LINE_WORD_BITS-1:0] w_word;
    logic [INDEX_BITS-1:0]     w_index;
    logic [TAG_BITS-1:0]       w_tag;
    logic [LINE_BITS-1:0]      w_line;
    logic [INDEX_BITS-1:0]     w_fill_index;
    logic [TAG_BITS-1:0]       w_fill_tag;
    logic [LINE_WORD_BITS-1:0] w_cnt_next;
    logic [DADDR_BITS-1:0]     w_rd_addr;
    logic                      w_lookup;
    logic                      w_accept;
    logic                      w_last;
    logic                      w_abort;
    logic                      w_fwd;
    logic                      w_ready;
    logic                      w_unused_addr;

    assign w_word        = if_addr[LINE_WORD_BITS+1:2];
    assign w_index       = if_addr[LINE_WORD_BITS+2 +: INDEX_BITS];
    assign w_tag         = if_addr[31 -: TAG_BITS];
    assign w_line        = if_addr[31 -: LINE_BITS];
    assign w_unused_addr = ^if_addr[1:0];

    assign w_fill_index = r_fill_line[INDEX_BITS-1:0];
    assign w_fill_tag   = r_fill_line[LINE_BITS-1 -: TAG_BITS];
    assign w_cnt_next   = r_fill_cnt + LINE_WORD_BITS'(1);
    assign w_rd_addr    = {w_index, w_word};

    assign w_lookup = r_valid[w_index] && (r_tag[w_index] == w_tag);
    // Ready from the controller only counts while a request is actually outstanding.
    assign w_accept = (r_state == S_FILL) && r_mc_valid && mc_ready;
    assign w_last   = &r_fill_cnt;
    assign w_abort  = r_clear_pend || clear;

    always_comb begin
        w_fwd = 1'b0;
`ifdef ICACHE_FORWARD_EN
        w_fwd = (r_state == S_FILL) && if_valid && !r_clear_pend &&
                (w_line == r_fill_line) && (w_word < r_fill_cnt);
`endif
        w_ready = ((r_state == S_IDLE) && if_valid && w_lookup) || w_fwd;
    end

    assign if_ready = w_ready;
    assign if_inst  = w_ready ? r_data[w_rd_addr] : 32'h0;
    assign mc_valid = r_mc_valid;
    assign mc_addr  = r_mc_addr;
    assign mc_wr    = 1'b0;
    assign mc_len   = 3'b010;
    assign mc_data  = 32'h0;

    // Control FSM: lookup in IDLE, sequential word reads in FILL.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_fill_line  <= '0;
            r_fill_cnt   <= '0;
            r_mc_valid   <= 1'b0;
            r_mc_addr    <= 32'h0;
            r_clear_pend <= 1'b0;
        end else if (rdy_in) begin
            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        r_valid <= '0;
                    end
                    if (if_valid && !w_lookup) begin
                        r_state          <= S_FILL;
                        r_fill_line      <= w_line;
                        r_fill_cnt       <= '0;
                        r_valid[w_index] <= 1'b0;
                        r_mc_valid       <= 1'b1;
                        r_mc_addr        <= {w_line, {LINE_WORD_BITS{1'b0}}, 2'b00};
                        r_clear_pend     <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (clear) begin
                        r_clear_pend <= 1'b1;
                    end
                    if (w_accept) begin
                        r_fill_cnt <= w_cnt_next;
                        // Address is held at the last word so a lingering ready cannot
                        // match the first address of the next refill.
                        if (w_last || w_abort) begin
                            r_mc_valid   <= 1'b0;
                            r_state      <= S_IDLE;
                            r_clear_pend <= 1'b0;
                            if (w_abort) begin
                                r_valid <= '0;
                            end else begin
                                r_valid[w_fill_index] <= 1'b1;
                            end
                        end else begin
                            r_mc_addr <= {r_fill_line, w_cnt_next, 2'b00};
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Data and tag arrays carry no reset; validity is tracked by r_valid alone.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && w_accept) begin
            r_data[{w_fill_index, r_fill_cnt}] <= mc_res;
            if (w_last && !w_abort) begin
                r_tag[w_fill_index] <= w_fill_tag;
            end
        end
    end

endmodule

// File: tb/tb_icache_fill_unit.sv
// Directed bench for icache_fill_unit with a small memory-controller model.
module tb_icache_fill_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_inst;
    logic        mc_valid;
    logic        mc_wr;
    logic [31:0] mc_addr;
    logic [2:0]  mc_len;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic [31:0] mc_res;

    int checks = 0;
    int errors = 0;

    logic [31:0] log_addr [64];
    int          log_n = 0;
    int          wait_cnt;
    int          base;

    icache_fill_unit dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .clear    (clear),
        .if_valid (if_valid),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_inst  (if_inst),
        .mc_valid (mc_valid),
        .mc_wr    (mc_wr),
        .mc_addr  (mc_addr),
        .mc_len   (mc_len),
        .mc_data  (mc_data),
        .mc_ready (mc_ready),
        .mc_res   (mc_res)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            32'hC:   return 32'h44;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    // Controller: one idle cycle per request, ready pulse held through stalls.
    always @(posedge clk_in) begin
        if (rst_in) begin
            mc_ready <= 1'b0;
            mc_res   <= 32'h0;
            wait_cnt <= 0;
        end else if (mc_ready) begin
            if (rdy_in) mc_ready <= 1'b0;
        end else if (mc_valid && rdy_in) begin
            if (wait_cnt == 1) begin
                mc_ready <= 1'b1;
                mc_res   <= mem_word(mc_addr);
                wait_cnt <= 0;
                if (log_n < 64) log_addr[log_n] <= mc_addr;
                log_n <= log_n + 1;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_hit(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (if_ready === 1'b1) break;
            tick();
        end
        chk(tag, 32'(if_ready), 32'h1);
    endtask

    task automatic wait_addr(input string tag, input logic [31:0] a, input int max);
        for (int i = 0; i < max; i++) begin
            if (mc_addr === a) break;
            tick();
        end
        chk(tag, mc_addr, a);
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (mc_valid === 1'b0) break;
            tick();
        end
        chk(tag, 32'(mc_valid), 32'h0);
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [31:0] a);
        if (idx < 64) chk(tag, log_addr[idx], a);
        else          chk(tag, 32'(idx), 32'(63));
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; if_valid = 1'b0; if_addr = 32'h0;
        repeat (3) tick();
        rst_in = 1'b0;
        #1;
        chk("rst_if_ready", 32'(if_ready), 32'h0);
        chk("rst_mc_valid", 32'(mc_valid), 32'h0);
        chk("rst_mc_addr", mc_addr, 32'h0);
        chk("rst_mc_wr", 32'(mc_wr), 32'h0);
        chk("rst_mc_len", 32'(mc_len), 32'h2);
        chk("rst_mc_data", mc_data, 32'h0);
        tick();

        // Cold miss on line 0
        if_valid = 1'b1; if_addr = 32'h0;
        #1;
        chk("t1_miss", 32'(if_ready), 32'h0);
        wait_hit("t1_hit", 40);
        chk("t1_inst", if_inst, 32'h11);
        chk("t1_log_n", 32'(log_n), 32'h4);
        chk_log("t1_a0", 0, 32'h0);
        chk_log("t1_a1", 1, 32'h4);
        chk_log("t1_a2", 2, 32'h8);
        chk_log("t1_a3", 3, 32'hC);
        chk("t1_mc_idle", 32'(mc_valid), 32'h0);

        // Zero-cycle hit
        if_addr = 32'h8;
        #1;
        chk("t2_hit", 32'(if_ready), 32'h1);
        chk("t2_inst", if_inst, 32'h33);
        tick();
        chk("t2_mc_idle", 32'(mc_valid), 32'h0);

        // Conflict miss and eviction
        if_addr = 32'h100;
        #1;
        chk("t3_miss", 32'(if_ready), 32'h0);
        wait_hit("t3_hit", 40);
        chk("t3_inst", if_inst, 32'hC0DE_0100);
        chk_log("t3_a0", 4, 32'h100);
        chk_log("t3_a3", 7, 32'h10C);
        if_addr = 32'h0;
        #1;
        chk("t3_evict", 32'(if_ready), 32'h0);
        wait_hit("t3_rehit", 40);
        chk("t3_reinst", if_inst, 32'h11);
        tick();

        // Clear during the second word of a fill
        base = log_n;
        if_addr = 32'h40;
        wait_addr("t4_addr44", 32'h44, 40);
        clear = 1'b1; if_valid = 1'b0;
        tick();
        clear = 1'b0;
        chk("t4_inflight", 32'(mc_valid), 32'h1);
        wait_idle("t4_idle", 20);
        chk("t4_log_n", 32'(log_n), 32'(base + 2));
        chk_log("t4_a1", base + 1, 32'h44);
        chk("t4_addr_hold", mc_addr, 32'h44);
        tick();
        if_valid = 1'b1; if_addr = 32'h40;
        #1;
        chk("t4_miss40", 32'(if_ready), 32'h0);
        wait_hit("t4_hit40", 40);
        chk("t4_inst40", if_inst, 32'hC0DE_0040);
        if_addr = 32'h0;
        #1;
        chk("t4_miss0", 32'(if_ready), 32'h0);
        wait_hit("t4_hit0", 40);
        tick();

        // Stall for 5 cycles mid-fill
        base = log_n;
        if_addr = 32'h80;
        wait_addr("t5_addr84", 32'h84, 40);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_stall_addr", mc_addr, 32'h84);
            chk("t5_stall_valid", 32'(mc_valid), 32'h1);
        end
        chk("t5_mc_wr", 32'(mc_wr), 32'h0);
        chk("t5_mc_len", 32'(mc_len), 32'h2);
        rdy_in = 1'b1;
        wait_hit("t5_hit", 40);
        chk("t5_inst", if_inst, 32'hC0DE_0080);
        chk("t5_log_n", 32'(log_n), 32'(base + 4));
        chk_log("t5_a1", base + 1, 32'h84);
        chk_log("t5_a2", base + 2, 32'h88);
        chk_log("t5_a3", base + 3, 32'h8C);
        if_addr = 32'h8C;
        #1;
        chk("t5_inst8c", if_inst, 32'hC0DE_008C);
        tick();

        // Request a filled word while the rest of the line is in flight
        if_addr = 32'h200;
        wait_addr("t6_addr208", 32'h208, 40);
        if_addr = 32'h204;
        #1;
`ifdef ICACHE_FORWARD_EN
        chk("t6_fwd_ready", 32'(if_ready), 32'h1);
        chk("t6_fwd_inst", if_inst, 32'hC0DE_0204);
        wait_idle("t6_idle", 20);
`else
        for (int i = 0; i < 20; i++) begin
            if (mc_valid !== 1'b1) break;
            chk("t6_no_fwd", 32'(if_ready), 32'h0);
            tick();
        end
        chk("t6_idle", 32'(mc_valid), 32'h0);
`endif
        chk("t6_hit", 32'(if_ready), 32'h1);
        chk("t6_inst", if_inst, 32'hC0DE_0204);
        tick();

        // Reset in the middle of a fill
        if_addr = 32'h300;
        tick();
        chk("t7_filling", 32'(mc_valid), 32'h1);
        rst_in = 1'b1;
        if_addr = 32'h80;
        tick();
        chk("t7_rst_valid", 32'(mc_valid), 32'h0);
        chk("t7_rst_addr", mc_addr, 32'h0);
        chk("t7_rst_miss", 32'(if_ready), 32'h0);
        rst_in = 1'b0;
        if_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
